// File: rtl/rotation_monitor.sv
// Observes a shifting/rotating register after each load and reports the rotation
// period, a stall (pattern stopped changing), or a timeout after LIMIT steps.
module rotation_monitor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned LIMIT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             loadn,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stalled,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ARM, TRACK, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] ref_q, ref_next;
  logic [WIDTH-1:0] q_prev;
  logic [CNT_W-1:0] steps_next, period_next, n;
  logic             period_valid_next, stalled_next, timeout_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      ref_q        <= '0;
      q_prev       <= '0;
      steps        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_next;
      ref_q        <= ref_next;
      q_prev       <= q_in;
      steps        <= steps_next;
      period       <= period_next;
      period_valid <= period_valid_next;
      stalled      <= stalled_next;
      timeout      <= timeout_next;
    end
  end

  assign n = steps + CNT_W'(1);

  // Reference match is tested before stall so constant patterns report period 1.
  always_comb begin
    state_next        = state;
    ref_next          = ref_q;
    steps_next        = steps;
    period_next       = period;
    period_valid_next = period_valid;
    stalled_next      = stalled;
    timeout_next      = timeout;
    unique case (state)
      IDLE: begin
        if (!loadn) state_next = ARM;
      end
      ARM: begin
        ref_next          = q_in;
        steps_next        = '0;
        period_next       = '0;
        period_valid_next = 1'b0;
        stalled_next      = 1'b0;
        timeout_next      = 1'b0;
        state_next        = loadn ? TRACK : ARM;
      end
      TRACK: begin
        if (!loadn) begin
          state_next = ARM;
        end else if (q_in == ref_q) begin
          period_next       = n;
          steps_next        = n;
          period_valid_next = 1'b1;
          state_next        = DONE;
        end else if (q_in == q_prev) begin
          steps_next   = n;
          stalled_next = 1'b1;
          state_next   = DONE;
        end else if (n == CNT_W'(LIMIT)) begin
          steps_next   = n;
          timeout_next = 1'b1;
          state_next   = DONE;
        end else begin
          steps_next = n;
        end
      end
      DONE: begin
        if (!loadn) state_next = ARM;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == ARM) || (state == TRACK);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rotation_monitor.sv
// Self-checking bench for rotation_monitor: emulates the observed register and
// predicts each outcome by searching the shift sequence for match/stall/limit.
module tb_rotation_monitor;

  localparam int LIMIT = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] q_in;
  logic       loadn;
  logic       busy, done, period_valid, stalled, timeout;
  logic [4:0] steps, period;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [7:0] seq [0:LIMIT];

  rotation_monitor #(.WIDTH(8), .CNT_W(5), .LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset), .q_in(q_in), .loadn(loadn),
    .busy(busy), .done(done), .steps(steps), .period(period),
    .period_valid(period_valid), .stalled(stalled), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_steps"}, 32'(steps), 0);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_flags"}, {29'd0, period_valid, stalled, timeout}, 0);
  endtask

  // mode 0: rotate left by r, 1: arithmetic shift right, 2: ramp, 3: random bytes
  task automatic build_seq(input logic [7:0] v0, input int mode, input int r);
    seq[0] = v0;
    for (int i = 1; i <= LIMIT; i++) begin
      case (mode)
        0:       seq[i] = 8'((seq[i-1] << r) | (seq[i-1] >> (8 - r)));
        1:       seq[i] = {seq[i-1][7], seq[i-1][7:1]};
        2:       seq[i] = 8'(v0 + i);
        default: seq[i] = 8'($urandom);
      endcase
    end
  endtask

  // kind 1 = period, 2 = stall, 3 = timeout; k = shift index at which it is decided
  task automatic predict(output int kind, output int k);
    kind = 3;
    k = LIMIT;
    for (int i = 1; i <= LIMIT; i++) begin
      if (seq[i] == seq[0]) begin kind = 1; k = i; break; end
      if (seq[i] == seq[i-1]) begin kind = 2; k = i; break; end
    end
  endtask

  // Load seq[0], then present seq[j] each cycle; stop early after steps==abort_at.
  task automatic run(input string tag, input int abort_at);
    int kind, k;
    predict(kind, k);
    loadn = 1'b0;
    step();                                   // E0
    q_in  = seq[0];
    loadn = 1'b1;
    check({tag, "_arm_busy"}, 32'(busy), 1);
    check({tag, "_arm_done"}, 32'(done), 0);
    step();                                   // E1
    q_in = seq[1];
    check({tag, "_e1_steps"}, 32'(steps), 0);
    check({tag, "_e1_flags"}, {29'd0, period_valid, stalled, timeout}, 0);
    check({tag, "_e1_busy"}, 32'(busy), 1);
    for (int j = 1; j <= k; j++) begin
      step();                                 // E(j+1)
      if (j < k) begin
        check({tag, "_trk_steps"}, 32'(steps), 32'(j));
        check({tag, "_trk_busy"}, 32'(busy), 1);
        check({tag, "_trk_done"}, 32'(done), 0);
        if (j == abort_at) return;
      end else begin
        check({tag, "_res_done"}, 32'(done), 1);
        check({tag, "_res_busy"}, 32'(busy), 0);
        check({tag, "_res_steps"}, 32'(steps), 32'(k));
        check({tag, "_res_period"}, 32'(period), (kind == 1) ? 32'(k) : 0);
        check({tag, "_res_flags"}, {29'd0, period_valid, stalled, timeout},
              (kind == 1) ? 4 : (kind == 2) ? 2 : 1);
      end
      q_in = (j + 1 <= LIMIT) ? seq[j+1] : 8'($urandom);
    end
    for (int h = 0; h < 2; h++) begin
      q_in = 8'($urandom);
      step();
      check({tag, "_hold_done"}, 32'(done), 1);
      check({tag, "_hold_steps"}, 32'(steps), 32'(k));
      check({tag, "_hold_flags"}, {29'd0, period_valid, stalled, timeout},
            (kind == 1) ? 4 : (kind == 2) ? 2 : 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    q_in  = 8'($urandom);
    loadn = 1'($urandom);
    step();
    q_in  = 8'($urandom);
    loadn = 1'($urandom);
    step();
    check_idle("reset");
    reset = 1'b0;
    loadn = 1'b1;
    step();
    check_idle("idle");

    build_seq(8'h01, 0, 1); run("rot01", -1);
    build_seq(8'h55, 0, 1); run("rot55", -1);
    build_seq(8'h00, 0, 1); run("const00", -1);
    build_seq(8'hFF, 1, 0); run("constFF", -1);
    build_seq(8'h80, 1, 0); run("asr80", -1);
    build_seq(8'h00, 2, 0); run("ramp", -1);

    build_seq(8'h01, 0, 1); run("reload_a", 3);
    build_seq(8'h11, 0, 1); run("reload_b", -1);

    build_seq(8'h00, 2, 0); run("rst_mid", 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("rst_mid_after");
    step();
    check_idle("rst_mid_idle");

    for (int t = 0; t < 24; t++) begin
      build_seq(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 7)));
      run("rand", ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rotation_monitor.md
# rotation_monitor

Downstream observer for the 8-bit rotating/shift register on the lab board. It shares the register's clock and watches the register's parallel output and its active-low load control. After each load it counts shift steps until one of three things happens: the pattern returns to the loaded value (rotation period), the pattern stops changing (arithmetic-shift convergence), or a step limit expires. Results drive status LEDs/HEX displays.

## Interface
- WIDTH, 8, width of the observed register
- CNT_W, 5, width of the step and period counters; 2^CNT_W must exceed LIMIT
- LIMIT, 16, maximum number of steps before timeout

- clock  in  1  shared with the observed register; all state updates on the rising edge
- reset  in  1  synchronous, active-high; dominates every other input
- q_in  in  WIDTH  observed register output Q
- loadn  in  1  the register's load control (low = the register loads on this edge)
- busy  out  1  high in ARM or TRACK
- done  out  1  high in DONE
- steps  out  CNT_W  live step count since the reference was captured
- period  out  CNT_W  detected rotation period; valid only with period_valid
- period_valid  out  1  pattern returned to the reference
- stalled  out  1  pattern stopped changing without matching the reference
- timeout  out  1  LIMIT steps elapsed with no match and no stall

## Operation
- Internal registers:
  - state: IDLE, ARM, TRACK or DONE
  - ref[WIDTH]: captured reference pattern
  - q_prev[WIDTH]: q_in delayed by one cycle; updated every non-reset cycle in every state
- The register outputs (steps, period, period_valid, stalled, timeout) change only as listed below. done and busy decode state.
- IDLE:
  - loadn=0 → ARM.
  - Otherwise stay.
- ARM (entered from any non-reset state whenever loadn=0 is sampled):
  - ref←q_in (the freshly loaded value); steps←0.
  - period←0; period_valid, stalled, timeout←0.
  - loadn=0 → stay in ARM and recapture next cycle. Otherwise → TRACK.
- TRACK, evaluated in priority order each edge with n=steps+1:
  1. loadn=0 → ARM.
  2. q_in==ref → period←n, steps←n, period_valid←1, → DONE.
  3. q_in==q_prev → steps←n, stalled←1, → DONE.
  4. n==LIMIT → steps←n, timeout←1, → DONE.
  5. Otherwise steps←n, stay in TRACK.
- DONE:
  - All outputs hold.
  - loadn=0 → ARM.
- At most one of period_valid, stalled and timeout is ever high.
- Reference match has priority over stall. A constant pattern such as 0x00 or 0xFF reports period 1, not stalled.
- Counters never wrap: the LIMIT check stops counting at LIMIT.

## Timing
- Reset value of every output and internal register is 0. State resets to IDLE.
- Reset asserted mid-operation returns the block to IDLE at that edge; flags and results clear.
- Load observed at edge E0 (loadn low in the preceding cycle):
  - E0: state=ARM.
  - E1: ref captured, state=TRACK, steps=0.
  - E(k+1): steps=k, the k-th comparison, made against the register value after shift k.
- Result latency: a period of P reports at edge E(P+1). A stall first visible at shift k reports at E(k+1). Timeout reports at E(LIMIT+1).
- No handshake: flags are levels that hold until the next load or reset.

## Test plan
- Reset: assert reset 2 cycles with arbitrary q_in/loadn → all outputs 0, busy=0, done=0.
- Rotate 0x01: load 0x01, then rotate left every cycle → at E9 done=1, period_valid=1, period=8, steps=8.
- Rotate 0x55: load 0x55, then rotate → period=2 at E3. Load 0x00 → period=1 at E2, stalled=0.
- Arithmetic shift right of 0x80: sequence C0,E0,F0,F8,FC,FE,FF,FF → at E9 stalled=1, steps=8, period_valid=0.
- Timeout: bench drives q_in directly with a ramp that never repeats, after loading 0x00 → timeout=1, steps=16 at E17.
- Reload and reset interaction:
  - Pulse loadn low at TRACK steps=3 → ARM next edge, flags and steps clear, new ref captured.
  - Assert reset at steps=5 → IDLE next edge.
